// File: rtl/pin_collector_pkg.sv
// Shared PIN package: packet type, keypad codes
// and collector state encoding.
package pin_collector_pkg;

  localparam int PIN_LEN = 4;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

endpackage

// File: rtl/pin_collector_inactivity_timer.sv
// Inactivity counter with clear and expire flag;
// also reusable for lockout timing.
module inactivity_timer #(
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // count up while running, clear on request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (run)
      count <= count + 1'b1;
  end

  assign expire = run && (count == LAST);

endmodule

// File: rtl/pin_collector.sv
// Keypad PIN collector: gathers four digits and
// presents them as a pinPac_t until released.
module pin_collector
  import pin_collector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output pinPac_t    pin_out,
  output logic [2:0] digit_count,
  output logic       busy,
  output logic       error
);

  localparam logic [2:0] FULL = 3'(PIN_LEN);

  state_t     state, state_n;
  pinPac_t    pin_n;
  logic [2:0] cnt_n;
  logic       err_n;
  logic       accept;
  logic       expire;
  logic       tmr_run;
  logic       tmr_clear;

  assign tmr_run = (state == COLLECT) &&
                   (digit_count != 3'd0);

  assign tmr_clear = (state != COLLECT) || !enable ||
                     accept || expire;

  inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .run   (tmr_run),
    .clear (tmr_clear),
    .expire(expire)
  );

  // state and all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pin_out     <= '0;
      digit_count <= '0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      pin_out     <= pin_n;
      digit_count <= cnt_n;
      error       <= err_n;
    end
  end

  assign busy = (state == COLLECT);

  // next-state, digit buffer and error decode
  always_comb begin
    state_n = state;
    pin_n   = pin_out;
    cnt_n   = digit_count;
    err_n   = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = COLLECT;
          pin_n   = '0;
          cnt_n   = '0;
        end
      end
      COLLECT: begin
        if (!enable) begin
          state_n = IDLE;
          pin_n   = '0;
          cnt_n   = '0;
        end else if (key_valid && key_code <= 4'd9) begin
          accept = 1'b1;
          unique case (digit_count)
            3'd0: pin_n.digit1 = key_code;
            3'd1: pin_n.digit2 = key_code;
            3'd2: pin_n.digit3 = key_code;
            3'd3: pin_n.digit4 = key_code;
            default: begin
              pin_n.digit1 = pin_out.digit2;
              pin_n.digit2 = pin_out.digit3;
              pin_n.digit3 = pin_out.digit4;
              pin_n.digit4 = key_code;
            end
          endcase
          if (digit_count != FULL)
            cnt_n = digit_count + 3'd1;
        end else if (key_valid && key_code == KEY_STAR) begin
          accept = 1'b1;
          pin_n  = '0;
          cnt_n  = '0;
        end else if (key_valid && key_code == KEY_HASH) begin
          accept = 1'b1;
          if (digit_count == FULL) begin
            state_n      = DONE;
            pin_n.status = 1'b1;
          end else begin
            err_n = 1'b1;
            pin_n = '0;
            cnt_n = '0;
          end
        end else if (expire) begin
          err_n = 1'b1;
          pin_n = '0;
          cnt_n = '0;
        end
      end
      DONE: begin
        if (!enable) begin
          state_n = IDLE;
          pin_n   = '0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        pin_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pin_collector.sv
// Directed bench for pin_collector with a short
// inactivity limit.
module tb_pin_collector;
  import pin_collector_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  pinPac_t    pin_out;
  logic [2:0] digit_count;
  logic       busy;
  logic       error;

  int checks = 0;
  int failures = 0;
  int hit;
  int errs;

  pin_collector #(.TIMEOUT_CYCLES(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .pin_out    (pin_out),
    .digit_count(digit_count),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic release_pin();
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_pin", 32'(pin_out), 32'h0);
    chk("rst_cnt", 32'(digit_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic 1,2,3,4,#
    enable = 1'b1;
    @(negedge clk);
    chk("busy_on", 32'(busy), 32'd1);
    press(4'd1); press(4'd2);
    press(4'd3); press(4'd4);
    chk("four_cnt", 32'(digit_count), 32'd4);
    chk("four_pin", 32'(pin_out), 32'h01234);
    press(KEY_HASH);
    chk("done_pin", 32'(pin_out), 32'h11234);
    chk("done_cnt", 32'(digit_count), 32'd4);
    chk("done_busy", 32'(busy), 32'd0);
    release_pin();
    chk("rel_pin", 32'(pin_out), 32'h0);
    chk("rel_busy", 32'(busy), 32'd0);

    // short confirm
    enable = 1'b1;
    @(negedge clk);
    press(4'd5); press(4'd6);
    press(KEY_HASH);
    chk("short_err", 32'(error), 32'd1);
    chk("short_cnt", 32'(digit_count), 32'd0);
    chk("short_st", 32'(pin_out.status), 32'd0);
    @(negedge clk);
    chk("short_err1", 32'(error), 32'd0);
    press(4'd7); press(4'd8);
    press(4'd9); press(4'd0);
    press(KEY_HASH);
    chk("retry_pin", 32'(pin_out), 32'h17890);
    release_pin();

    // overflow keeps last four
    enable = 1'b1;
    @(negedge clk);
    for (int d = 1; d <= 6; d++) press(4'(d));
    chk("ovf_cnt", 32'(digit_count), 32'd4);
    press(KEY_HASH);
    chk("ovf_pin", 32'(pin_out), 32'h13456);
    release_pin();

    // timeout after 20 idle cycles
    enable = 1'b1;
    @(negedge clk);
    press(4'd9);
    hit = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (error && hit == 0) hit = i;
    end
    chk("to_cycle", 32'(hit), 32'd20);
    chk("to_cnt", 32'(digit_count), 32'd0);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (error) errs++;
    end
    chk("idle_noerr", 32'(errs), 32'd0);

    // key on the expiry cycle wins
    press(4'd9);
    repeat (19) @(negedge clk);
    press(4'd7);
    chk("race_err", 32'(error), 32'd0);
    chk("race_cnt", 32'(digit_count), 32'd2);
    chk("race_pin", 32'(pin_out), 32'h09700);
    @(negedge clk);
    chk("race_err1", 32'(error), 32'd0);
    release_pin();

    // clear, ignored codes, frozen DONE
    enable = 1'b1;
    @(negedge clk);
    press(4'd1); press(4'd2);
    press(KEY_STAR);
    chk("star_cnt", 32'(digit_count), 32'd0);
    press(4'd3); press(4'hC);
    chk("ign_cnt", 32'(digit_count), 32'd1);
    press(4'd4); press(4'd5); press(4'd6);
    press(KEY_HASH);
    chk("star_pin", 32'(pin_out), 32'h13456);
    press(4'd7); press(4'd8);
    press(KEY_HASH);
    chk("frz_pin", 32'(pin_out), 32'h13456);
    chk("frz_cnt", 32'(digit_count), 32'd4);
    release_pin();

    // enable drop beats confirm
    enable = 1'b1;
    @(negedge clk);
    press(4'd1); press(4'd2);
    press(4'd3); press(4'd4);
    enable = 1'b0;
    press(KEY_HASH);
    chk("abort_pin", 32'(pin_out), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_st", 32'(pin_out.status), 32'd0);

    // async reset in DONE
    enable = 1'b1;
    @(negedge clk);
    press(4'd4); press(4'd3);
    press(4'd2); press(4'd1);
    press(KEY_HASH);
    chk("pre_rst", 32'(pin_out), 32'h14321);
    #2 rst = 1'b1;
    #1;
    chk("async_pin", 32'(pin_out), 32'h0);
    chk("async_cnt", 32'(digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
